mem_req_arbiter: RTL



---
 rtl/mem_req_arbiter_pkg.sv | 17 +
 rtl/mem_req_arbiter_src_fifo.sv | 60 ++++++
 rtl/mem_req_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// Shared definitions for the inst/data memory request arbiter.
// Source encoding, request bus width helper and the default bus width.
package mem_req_arbiter_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  // Packed request bus: {wr, size[1:0], wstrb[3:0], addr, wdata}
  function automatic int mem_req_bus_wd(input int aw, input int dw);
    return 1 + 2 + 4 + aw + dw;
  endfunction

  localparam int MEM_REQ_BUS_WD = mem_req_bus_wd(32, 32);

endpackage

// File: rtl/mem_req_arbiter_src_fifo.sv
// arb_src_fifo: DEPTH-entry order FIFO remembering which master owns each
// outstanding memory transaction. Push when full and pop when empty are ignored.
module arb_src_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  src_e din,
  output logic full,
  output logic empty,
  output src_e head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  src_e          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == DEPTH_C);
  assign empty   = (cnt_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointer and occupancy next-state; DEPTH is a power of two so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  // Storage and pointer registers; reset discards all outstanding entries
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= SRC_INST;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push) mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one sram-like memory port between the inst and data
// masters. Zero added latency on request and response paths; responses are
// steered back using an in-order source FIFO.
// Optional feature macro: ARB_RR_EN (round-robin unlocked selection; default
// build uses fixed data > inst priority).
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int OUTST = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          inst_sram_req,
  input  logic          inst_sram_wr,
  input  logic [1:0]    inst_sram_size,
  input  logic [3:0]    inst_sram_wstrb,
  input  logic [AW-1:0] inst_sram_addr,
  input  logic [DW-1:0] inst_sram_wdata,
  output logic          inst_sram_addr_ok,
  output logic          inst_sram_data_ok,
  output logic [DW-1:0] inst_sram_rdata,
  input  logic          data_sram_req,
  input  logic          data_sram_wr,
  input  logic [1:0]    data_sram_size,
  input  logic [3:0]    data_sram_wstrb,
  input  logic [AW-1:0] data_sram_addr,
  input  logic [DW-1:0] data_sram_wdata,
  output logic          data_sram_addr_ok,
  output logic          data_sram_data_ok,
  output logic [DW-1:0] data_sram_rdata,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [1:0]    mem_size,
  output logic [3:0]    mem_wstrb,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_addr_ok,
  input  logic          mem_data_ok,
  input  logic [DW-1:0] mem_rdata
);

  localparam int BUS_WD = mem_req_bus_wd(AW, DW);

  src_e              src;
  src_e              lock_src_q, lock_src_d;
  logic              lock_vld_q, lock_vld_d;
  logic              req_sel;
  logic              req_go;
  logic              accept;
  logic              pop;
  logic              fifo_full, fifo_empty;
  src_e              fifo_head;
  logic [BUS_WD-1:0] inst_bus, data_bus, sel_bus;

`ifdef ARB_RR_EN
  src_e rr_last_q, rr_last_d;
`endif

  // Source selection: a pending (locked) request always keeps the grant
  always_comb begin
    src = SRC_INST;
    if (lock_vld_q) begin
      src = lock_src_q;
`ifdef ARB_RR_EN
    end else if (inst_sram_req && data_sram_req) begin
      src = (rr_last_q == SRC_INST) ? SRC_DATA : SRC_INST;
`endif
    end else if (data_sram_req) begin
      src = SRC_DATA;
    end
  end

  assign inst_bus = {inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata};
  assign data_bus = {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata};
  assign sel_bus  = (src == SRC_DATA) ? data_bus : inst_bus;
  assign req_sel  = (src == SRC_DATA) ? data_sram_req : inst_sram_req;

  // Internal handshake terms stay free of resetn; only the outputs are gated
  assign req_go = req_sel & ~fifo_full;
  assign accept = req_go & mem_addr_ok;
  assign pop    = mem_data_ok & ~fifo_empty;

  assign mem_req = resetn & req_go;
  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = resetn ? sel_bus : '0;

  assign inst_sram_addr_ok = resetn & accept & (src == SRC_INST);
  assign data_sram_addr_ok = resetn & accept & (src == SRC_DATA);

  assign inst_sram_data_ok = resetn & pop & (fifo_head == SRC_INST);
  assign data_sram_data_ok = resetn & pop & (fifo_head == SRC_DATA);
  assign inst_sram_rdata   = inst_sram_data_ok ? mem_rdata : '0;
  assign data_sram_rdata   = data_sram_data_ok ? mem_rdata : '0;

  // Lock next-state: hold the grant while a request waits for mem_addr_ok
  always_comb begin
    lock_vld_d = lock_vld_q;
    lock_src_d = lock_src_q;
    if (req_go && !mem_addr_ok) begin
      lock_vld_d = 1'b1;
      lock_src_d = src;
    end else if (accept) begin
      lock_vld_d = 1'b0;
    end
  end

  // Lock registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_vld_q <= 1'b0;
      lock_src_q <= SRC_INST;
    end else begin
      lock_vld_q <= lock_vld_d;
      lock_src_q <= lock_src_d;
    end
  end

`ifdef ARB_RR_EN
  // Round-robin history: remember the last accepted source
  always_comb begin
    rr_last_d = rr_last_q;
    if (accept) rr_last_d = src;
  end

  // Round-robin history register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rr_last_q <= SRC_INST;
    else         rr_last_q <= rr_last_d;
  end
`endif

  arb_src_fifo #(
    .DEPTH (OUTST)
  ) u_src_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (accept),
    .pop    (pop),
    .din    (src),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

endmodule
